gpr_writeback: RTL and testbench
================================

Name: gpr_writeback

Overview:
Writeback stage that sits directly upstream of the 8x16 GPR file and drives its write port. It merges single-cycle ALU results with load-unit results arriving under valid/ready flow control, and buffers loads in a small FIFO when they collide with ALU writes. It also keeps a per-register pending scoreboard so decode can stall on read-after-write hazards.

Parameters:
DATA_W, 16, register data width
ADDR_W, 3, register address width
NUM_REGS, 8, number of GPRs (2**ADDR_W)
LD_DEPTH, 2, load buffer depth (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present this cycle (no backpressure)
alu_dest  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load result accepted when ld_valid && ld_ready
ld_dest  in  ADDR_W  load destination register
ld_data  in  DATA_W  load data
issue_valid  in  1  decode issues an instruction that will write issue_dest
issue_dest  in  ADDR_W  destination marked pending
reg_read_addr_1  in  ADDR_W  decode read address 1 (same net the GPR file sees)
reg_read_addr_2  in  ADDR_W  decode read address 2
rd_busy_1  out  1  reg_read_addr_1 has a pending write
rd_busy_2  out  1  reg_read_addr_2 has a pending write
busy_vec  out  NUM_REGS  scoreboard bits, bit i = register i pending
reg_write_en  out  1  to GPR file write enable
reg_write_dest  out  ADDR_W  to GPR file write address
reg_write_data  out  DATA_W  to GPR file write data

Behaviour:
- Reset (rst=1 at edge): reg_write_en=0, reg_write_dest=0, reg_write_data=0, FIFO empty (pointers and count 0), busy_vec=0. ld_ready=0 while rst is high.
- ld_ready = !rst && (count < LD_DEPTH). Combinational from state only; must not depend on alu_valid or ld_valid.
- Write-port outputs are registered. A result selected in cycle N appears on reg_write_* in cycle N+1 with reg_write_en=1 for exactly one cycle per result.
- Selection priority per cycle:
  - alu_valid=1: select ALU. An accepted load is pushed to the FIFO.
  - alu_valid=0, FIFO non-empty: pop the head and select it. An accepted load is pushed. Push and pop in the same cycle leave count unchanged.
  - alu_valid=0, FIFO empty, ld accepted: bypass. Select the load directly without a push.
  - nothing selected: reg_write_en=0 next cycle. reg_write_dest and reg_write_data hold their last values.
- Loads are written strictly in acceptance order. No load is dropped or duplicated.
- Scoreboard:
  - issue_valid sets busy_vec[issue_dest] at the edge.
  - Each edge where reg_write_en=1 clears busy_vec[reg_write_dest]. The bit therefore falls the cycle after the GPR commits, so decode never reads stale data.
  - If set and clear target the same register at the same edge, set wins.
  - Set on an already-busy bit: bit stays 1. Decode must not issue WAW to a busy register.
- rd_busy_1 = busy_vec[reg_read_addr_1] and rd_busy_2 = busy_vec[reg_read_addr_2]. Both are combinational from registered state.
- Reset mid-operation: FIFO contents and in-flight write are discarded. reg_write_en is 0 the cycle after the reset edge.
- All register indices, including 0, are writable. There is no hardwired-zero register.

Test Plan:
- Reset: rst=1 two cycles with ld_valid=1 -> ld_ready=0, reg_write_en=0, busy_vec=8'h00. Release -> ld_ready=1.
- ALU only: alu_valid=1, dest=3, data=16'h1234 in cycle N -> reg_write_en=1, dest=3, data=16'h1234 in N+1. reg_write_en=0 in N+2.
- Load bypass plus scoreboard: issue dest=5, then ld dest=5, data=16'hBEEF accepted in cycle N -> busy_vec[5]=1 through N+1, write in N+1, rd_busy=0 for addr 5 in N+2.
- Collision and buffering: alu_valid and ld_valid for 3 consecutive cycles, ld data A,B,C. ALU writes occur in cycles 1-3. Loads A and B buffer and ld_ready=0 in cycle 3 (C stalls). After alu_valid drops, A, B, C are written in order on consecutive cycles.
- Scoreboard set/clear race: reg 2 busy. The reg_write_en edge for dest 2 coincides with issue_valid dest 2 -> busy_vec[2] stays 1.
- Mid-operation reset: FIFO holds 2 entries, rst=1 for 1 cycle -> no further writes, count=0, busy_vec=0, ld_ready=1 after release.

Source files
------------

// File: rtl/gpr_writeback.sv
// Writeback stage feeding the GPR write port: merges ALU and load results,
// buffers colliding loads in order, and tracks pending destinations for decode.
module gpr_writeback #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int LD_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_dest,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_dest,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic [ADDR_W-1:0]   reg_read_addr_1,
    input  logic [ADDR_W-1:0]   reg_read_addr_2,
    output logic                rd_busy_1,
    output logic                rd_busy_2,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                reg_write_en,
    output logic [ADDR_W-1:0]   reg_write_dest,
    output logic [DATA_W-1:0]   reg_write_data
);

    localparam int PTR_W = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(LD_DEPTH);

    logic [DATA_W-1:0] fifo_data [LD_DEPTH];
    logic [ADDR_W-1:0] fifo_dest [LD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              ld_accept;
    logic              push;
    logic              pop;
    logic              sel_en_p0;
    logic [ADDR_W-1:0] sel_dest_p0;
    logic [DATA_W-1:0] sel_data_p0;
    logic [NUM_REGS-1:0] busy_next;

    assign ld_ready  = !rst && (count < FULL_COUNT);
    assign ld_accept = ld_valid && ld_ready;

    // Stage p0: pick this cycle's result; ALU first, then buffered loads, then bypass
    always_comb begin
        push        = 1'b0;
        pop         = 1'b0;
        sel_en_p0   = 1'b0;
        sel_dest_p0 = alu_dest;
        sel_data_p0 = alu_data;
        if (alu_valid) begin
            sel_en_p0 = 1'b1;
            push      = ld_accept;
        end else if (count != '0) begin
            sel_en_p0   = 1'b1;
            sel_dest_p0 = fifo_dest[rd_ptr];
            sel_data_p0 = fifo_data[rd_ptr];
            pop         = 1'b1;
            push        = ld_accept;
        end else if (ld_accept) begin
            sel_en_p0   = 1'b1;
            sel_dest_p0 = ld_dest;
            sel_data_p0 = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ld_data;
            fifo_dest[wr_ptr] <= ld_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // Stage p1: registered write port; dest/data hold when nothing is selected
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else begin
            reg_write_en <= sel_en_p0;
            if (sel_en_p0) begin
                reg_write_dest <= sel_dest_p0;
                reg_write_data <= sel_data_p0;
            end
        end
    end

    // Clear follows the GPR commit by one edge; a same-edge set overrides it
    always_comb begin
        busy_next = busy_vec;
        if (reg_write_en) busy_next[reg_write_dest] = 1'b0;
        if (issue_valid)  busy_next[issue_dest]     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= busy_next;
    end

    assign rd_busy_1 = busy_vec[reg_read_addr_1];
    assign rd_busy_2 = busy_vec[reg_read_addr_2];

endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback: reset, ALU path, load bypass, collision
// buffering, scoreboard set/clear race and mid-operation reset.
module tb_gpr_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_dest;
    logic [15:0] ld_data;
    logic        issue_valid;
    logic [2:0]  issue_dest;
    logic [2:0]  reg_read_addr_1;
    logic [2:0]  reg_read_addr_2;
    logic        rd_busy_1;
    logic        rd_busy_2;
    logic [7:0]  busy_vec;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;

    int errors = 0;
    int checks = 0;

    gpr_writeback #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .LD_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .reg_read_addr_1(reg_read_addr_1), .reg_read_addr_2(reg_read_addr_2),
        .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2), .busy_vec(busy_vec),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_valid = 1'b1; ld_dest = 3'd1; ld_data = 16'h5555;
        tick();
        tick();
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        checks++;
        if (reg_write_en !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", reg_write_en); end
        checks++;
        if (busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy: got %h want 00", busy_vec); end
        checks++;
        if (reg_write_dest !== 3'd0 || reg_write_data !== 16'h0000) begin
            errors++; $display("FAIL reset_wport: got %0d/%h want 0/0000", reg_write_dest, reg_write_data);
        end
        ld_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL release_ld_ready: got %b want 1", ld_ready); end
    endtask

    task automatic test_alu_only();
        alu_valid = 1'b1; alu_dest = 3'd3; alu_data = 16'h1234;
        tick();
        alu_valid = 1'b0;
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd3 || reg_write_data !== 16'h1234) begin
            errors++; $display("FAIL alu_write: got en=%b d=%0d %h want 1 3 1234", reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
        checks++;
        if (reg_write_en !== 1'b0) begin errors++; $display("FAIL alu_single_pulse: got %b want 0", reg_write_en); end
    endtask

    task automatic test_load_bypass();
        issue_valid = 1'b1; issue_dest = 3'd5;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy_vec !== 8'h20) begin errors++; $display("FAIL issue_set: got %h want 20", busy_vec); end
        ld_valid = 1'b1; ld_dest = 3'd5; ld_data = 16'hBEEF; reg_read_addr_1 = 3'd5;
        #1;
        checks++;
        if (ld_ready !== 1'b1 || rd_busy_1 !== 1'b1) begin
            errors++; $display("FAIL bypass_pre: got rdy=%b busy=%b want 1 1", ld_ready, rd_busy_1);
        end
        tick();
        ld_valid = 1'b0;
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd5 || reg_write_data !== 16'hBEEF) begin
            errors++; $display("FAIL bypass_write: got en=%b d=%0d %h want 1 5 beef", reg_write_en, reg_write_dest, reg_write_data);
        end
        checks++;
        if (busy_vec !== 8'h20) begin errors++; $display("FAIL busy_during_write: got %h want 20", busy_vec); end
        tick();
        checks++;
        if (rd_busy_1 !== 1'b0 || busy_vec !== 8'h00 || reg_write_en !== 1'b0) begin
            errors++; $display("FAIL busy_cleared: got busy=%b vec=%h en=%b want 0 00 0", rd_busy_1, busy_vec, reg_write_en);
        end
    endtask

    task automatic test_collision();
        logic [15:0] lds [3];
        logic [2:0]  ldd [3];
        logic        rdy_exp [3];
        lds[0] = 16'hAAAA; lds[1] = 16'hBBBB; lds[2] = 16'hCCCC;
        ldd[0] = 3'd4;     ldd[1] = 3'd5;     ldd[2] = 3'd6;
        rdy_exp[0] = 1'b1; rdy_exp[1] = 1'b1; rdy_exp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dest = 3'(i + 1); alu_data = 16'hA000 + 16'(i);
            ld_valid = 1'b1; ld_dest = ldd[i]; ld_data = lds[i];
            #1;
            checks++;
            if (ld_ready !== rdy_exp[i]) begin errors++; $display("FAIL coll_ready%0d: got %b want %b", i, ld_ready, rdy_exp[i]); end
            tick();
            checks++;
            if (reg_write_en !== 1'b1 || reg_write_dest !== 3'(i + 1) || reg_write_data !== 16'hA000 + 16'(i)) begin
                errors++; $display("FAIL coll_alu%0d: got en=%b d=%0d %h", i, reg_write_en, reg_write_dest, reg_write_data);
            end
        end
        alu_valid = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin errors++; $display("FAIL coll_full_stall: got %b want 0", ld_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 1) ld_valid = 1'b0;
            checks++;
            if (reg_write_en !== 1'b1 || reg_write_dest !== ldd[i] || reg_write_data !== lds[i]) begin
                errors++; $display("FAIL coll_drain%0d: got en=%b d=%0d %h want 1 %0d %h", i, reg_write_en, reg_write_dest, reg_write_data, ldd[i], lds[i]);
            end
        end
        tick();
        checks++;
        if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd6 || reg_write_data !== 16'hCCCC) begin
            errors++; $display("FAIL coll_idle_hold: got en=%b d=%0d %h want 0 6 cccc", reg_write_en, reg_write_dest, reg_write_data);
        end
    endtask

    task automatic test_race();
        issue_valid = 1'b1; issue_dest = 3'd2;
        tick();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h0F0F;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_dest = 3'd2;
        checks++;
        if (reg_write_en !== 1'b1 || busy_vec !== 8'h04) begin
            errors++; $display("FAIL race_pre: got en=%b vec=%h want 1 04", reg_write_en, busy_vec);
        end
        tick();
        issue_valid = 1'b0;
        checks++;
        if (busy_vec !== 8'h04) begin errors++; $display("FAIL race_set_wins: got %h want 04", busy_vec); end
        reg_read_addr_2 = 3'd2;
        #1;
        checks++;
        if (rd_busy_2 !== 1'b1) begin errors++; $display("FAIL race_rd_busy2: got %b want 1", rd_busy_2); end
        alu_valid = 1'b1; alu_dest = 3'd2; alu_data = 16'h0000;
        tick();
        alu_valid = 1'b0;
        tick();
        checks++;
        if (busy_vec !== 8'h00 || rd_busy_2 !== 1'b0) begin
            errors++; $display("FAIL race_final_clear: got %h/%b want 00/0", busy_vec, rd_busy_2);
        end
    endtask

    task automatic test_midreset();
        issue_valid = 1'b1; issue_dest = 3'd0;
        alu_valid = 1'b1; alu_dest = 3'd1; alu_data = 16'h1111;
        ld_valid = 1'b1; ld_dest = 3'd0; ld_data = 16'hD00D;
        tick();
        issue_valid = 1'b0;
        ld_data = 16'hD11D;
        tick();
        alu_valid = 1'b0; ld_valid = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b0 || busy_vec !== 8'h01) begin
            errors++; $display("FAIL midrst_pre: got rdy=%b vec=%h want 0 01", ld_ready, busy_vec);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (reg_write_en !== 1'b0 || busy_vec !== 8'h00) begin
            errors++; $display("FAIL midrst_state: got en=%b vec=%h want 0 00", reg_write_en, busy_vec);
        end
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ld_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (reg_write_en !== 1'b0) begin errors++; $display("FAIL midrst_no_write%0d: got %b want 0", i, reg_write_en); end
        end
        ld_valid = 1'b1; ld_dest = 3'd0; ld_data = 16'h7777;
        tick();
        ld_valid = 1'b0;
        checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd0 || reg_write_data !== 16'h7777) begin
            errors++; $display("FAIL midrst_bypass_r0: got en=%b d=%0d %h want 1 0 7777", reg_write_en, reg_write_dest, reg_write_data);
        end
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
        ld_valid = 1'b0; ld_dest = '0; ld_data = '0;
        issue_valid = 1'b0; issue_dest = '0;
        reg_read_addr_1 = '0; reg_read_addr_2 = '0;
        #2;
        test_reset();
        test_alu_only();
        test_load_bypass();
        test_collision();
        test_race();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
